debounce_bank: RTL and testbench



---
 rtl/debounce_bank.sv | 89 ++++++++
 tb/tb_debounce_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent push-button debouncers. Each channel has a
// synchroniser, a stability filter, rise/fall pulses and a one-shot long-press pulse.
module debounce_bank #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 50000,
  parameter int HOLD_W      = 24,
  parameter int HOLD_CNT    = 10000000,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig_in,
  output logic [N_CH-1:0] sig_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_pulse
);

  localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(HOLD_CNT - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   candidate;
    logic [CNT_W-1:0]       cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   long_done;
    logic                   out_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   long_q;

    assign sync = sync_q[SYNC_STAGES-1];

    // The stability counter saturates rather than wrapping, so a long-stable
    // input keeps its output without re-triggering; the hold counter likewise
    // freezes after the long-press pulse until the output drops.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q    <= {SYNC_STAGES{RESET_LEVEL}};
        candidate <= RESET_LEVEL;
        cnt       <= '0;
        out_q     <= RESET_LEVEL;
        hold_cnt  <= '0;
        long_done <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        long_q <= 1'b0;

        if (sync != candidate) begin
          candidate <= sync;
          cnt       <= '0;
        end else if (cnt < STABLE_MAX) begin
          cnt <= cnt + 1'b1;
        end else if (candidate != out_q) begin
          out_q  <= candidate;
          rise_q <= candidate;
          fall_q <= ~candidate;
        end

        if (!out_q) begin
          hold_cnt  <= '0;
          long_done <= 1'b0;
        end else if (!long_done) begin
          if (hold_cnt == HOLD_MAX) begin
            long_q    <= 1'b1;
            long_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end
    end

    assign sig_out[i]    = out_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
    assign long_pulse[i] = long_q;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: table-driven, directed and randomized checks of debounce_bank
// against a history-based reference model of the debounce rules.
module tb_debounce_bank;

  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 16;
  localparam int STABLE_CNT  = 4;
  localparam int HOLD_W      = 24;
  localparam int HOLD_CNT    = 10;
  localparam bit RESET_LEVEL = 1'b0;
  localparam int MAXE        = 8192;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] sig_in = '0;
  logic [N_CH-1:0] sig_out, rise_pulse, fall_pulse, long_pulse;

  int checks   = 0;
  int failures = 0;

  // Model state: inputs recorded per edge, outputs derived from that history.
  int              edge_no = 0;
  int              last_rst_edge = 0;
  logic [N_CH-1:0] in_hist [MAXE];
  logic [N_CH-1:0] m_out  = '0;
  logic [N_CH-1:0] m_rise = '0;
  logic [N_CH-1:0] m_fall = '0;
  logic [N_CH-1:0] m_long = '0;
  int              rise_edge [N_CH];

  typedef struct {
    logic            r;
    logic [N_CH-1:0] in;
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] lng;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT),
    .HOLD_W(HOLD_W), .HOLD_CNT(HOLD_CNT), .RESET_LEVEL(RESET_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .sig_out(sig_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .long_pulse(long_pulse)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
    end
  endtask

  // Synchronised value seen by the filter at edge j: the raw input from
  // SYNC_STAGES edges earlier, or the reset level while the chain refills.
  function automatic logic syncAt(input int ch, input int j);
    if (j - SYNC_STAGES >= last_rst_edge + 1)
      return in_hist[(j - SYNC_STAGES) % MAXE][ch];
    return RESET_LEVEL;
  endfunction

  task automatic modelEdge(input logic r, input logic [N_CH-1:0] v);
    logic [N_CH-1:0] prev;
    logic            stable;
    edge_no++;
    in_hist[edge_no % MAXE] = v;
    if (r) begin
      last_rst_edge = edge_no;
      m_out  = {N_CH{RESET_LEVEL}};
      m_rise = '0;
      m_fall = '0;
      m_long = '0;
      for (int c = 0; c < N_CH; c++) rise_edge[c] = edge_no;
    end else begin
      prev = m_out;
      for (int c = 0; c < N_CH; c++) begin
        m_long[c] = prev[c] && (edge_no - rise_edge[c] == HOLD_CNT);
        stable = (edge_no - STABLE_CNT >= last_rst_edge);
        for (int k = edge_no - STABLE_CNT; k <= edge_no && stable; k++)
          if (syncAt(c, k) != syncAt(c, edge_no)) stable = 1'b0;
        if (stable) m_out[c] = syncAt(c, edge_no);
        m_rise[c] = !prev[c] && m_out[c];
        m_fall[c] = prev[c] && !m_out[c];
        if (m_rise[c]) rise_edge[c] = edge_no;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N_CH-1:0] v);
    @(negedge clk);
    rst    = r;
    sig_in = v;
    @(posedge clk);
    modelEdge(r, v);
    #1;
    checkOutput("model_sig_out",    int'(sig_out),    int'(m_out));
    checkOutput("model_rise_pulse", int'(rise_pulse), int'(m_rise));
    checkOutput("model_fall_pulse", int'(fall_pulse), int'(m_fall));
    checkOutput("model_long_pulse", int'(long_pulse), int'(m_long));
  endtask

  // Holds v for n edges and reports when channel ch produced each event,
  // counted from 1 at the first edge that samples v.
  task automatic runFor(input logic [N_CH-1:0] v, input int n, input int ch,
                        output int rise_at, output int rise_n, output int fall_at,
                        output int long_at, output int long_n);
    rise_at = -1; rise_n = 0; fall_at = -1; long_at = -1; long_n = 0;
    for (int e = 1; e <= n; e++) begin
      applyStimulus(1'b0, v);
      if (rise_pulse[ch]) begin rise_n++; if (rise_at < 0) rise_at = e; end
      if (fall_pulse[ch] && fall_at < 0) fall_at = e;
      if (long_pulse[ch]) begin long_n++; if (long_at < 0) long_at = e; end
    end
  endtask

  task automatic settle();
    for (int e = 0; e < 20; e++) applyStimulus(1'b0, '0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ra, rn, fa, la, ln, spur;
    int rise_at [N_CH];
    logic [N_CH-1:0] cur;

    // Reset for 3 edges, then a clean step on channel 0.
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 3; i < 9; i++)
      tbl[i] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].r, tbl[i].in);
      checkOutput("tbl_sig_out",    int'(sig_out),    int'(tbl[i].out));
      checkOutput("tbl_rise_pulse", int'(rise_pulse), int'(tbl[i].rise));
      checkOutput("tbl_fall_pulse", int'(fall_pulse), int'(tbl[i].fall));
      checkOutput("tbl_long_pulse", int'(long_pulse), int'(tbl[i].lng));
    end
    settle();

    $display("[TB] bounce on channel 1");
    applyStimulus(1'b0, 4'b0010);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0010);
    applyStimulus(1'b0, 4'b0000);
    runFor(4'b0010, 12, 1, ra, rn, fa, la, ln);
    checkOutput("bounce_rise_edge", ra, 7);
    checkOutput("bounce_rise_count", rn, 1);
    settle();

    $display("[TB] short glitch on channel 2");
    runFor(4'b0100, 3, 2, ra, rn, fa, la, ln);
    checkOutput("glitch_rise_during", rn, 0);
    runFor(4'b0000, 12, 2, ra, rn, fa, la, ln);
    checkOutput("glitch_rise_after", rn, 0);
    checkOutput("glitch_fall_after", fa, -1);
    settle();

    $display("[TB] long press on channel 3");
    runFor(4'b1000, 30, 3, ra, rn, fa, la, ln);
    checkOutput("long_rise_edge", ra, 7);
    checkOutput("long_pulse_edge", la, 17);
    checkOutput("long_pulse_count", ln, 1);
    runFor(4'b0000, 12, 3, ra, rn, fa, la, ln);
    checkOutput("long_release_fall_edge", fa, 7);
    runFor(4'b1000, 8, 3, ra, rn, fa, la, ln);
    checkOutput("short_press_rise_edge", ra, 7);
    checkOutput("short_press_long_count", ln, 0);
    runFor(4'b0000, 12, 3, ra, rn, fa, la, ln);
    checkOutput("short_release_long_count", ln, 0);
    checkOutput("short_release_fall_edge", fa, 7);
    settle();

    $display("[TB] all channels together");
    for (int c = 0; c < N_CH; c++) rise_at[c] = -1;
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b0, 4'b1111);
      for (int c = 0; c < N_CH; c++)
        if (rise_pulse[c] && rise_at[c] < 0) rise_at[c] = e;
    end
    for (int c = 0; c < N_CH; c++) checkOutput("parallel_rise_edge", rise_at[c], 7);
    settle();

    $display("[TB] reset in the middle of a count");
    spur = 0;
    for (int e = 1; e <= 4; e++) begin
      applyStimulus(1'b0, 4'b0001);
      spur += $countones({rise_pulse, fall_pulse, long_pulse});
    end
    applyStimulus(1'b1, 4'b0001);
    checkOutput("midreset_sig_out", int'(sig_out), 0);
    ra = -1;
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b0, 4'b0001);
      spur += $countones({rise_pulse, fall_pulse, long_pulse});
      if (rise_pulse[0] && ra < 0) ra = e;
    end
    checkOutput("midreset_rise_edge", ra, 7);
    checkOutput("midreset_pulse_total", spur, 1);
    settle();

    $display("[TB] randomized traffic");
    cur = '0;
    for (int e = 0; e < 800; e++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 9) == 0) cur[c] = ~cur[c];
      applyStimulus($urandom_range(0, 199) == 0, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
